// File: rtl/head_packer.sv
// Packs signed int8 pixels from a show-ahead FIFO into 4x16-bit words, flagging the frame's last word.
// Optional HEAD_PACKER_SCALE_EN: each element is left-shifted by SHIFT and saturated to int16.
module head_packer #(
  parameter int IN_WIDTH  = 1,
  parameter int IN_HEIGHT = 1,
  parameter int SHIFT     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_empty,
  output logic        fifo_rd_en,
  input  logic        i_almost_full,
  output logic [63:0] o_data,
  output logic        o_valid,
  output logic        o_last
);
  localparam int TOTAL = IN_WIDTH * IN_HEIGHT;
  localparam int PW    = $clog2(TOTAL) + 1;

  typedef enum logic {COLLECT, STALL} state_t;

  if (SHIFT < 0 || SHIFT > 15) begin : g_bad_shift
    $error("head_packer: SHIFT must be in 0..15");
  end

  state_t           state;
  logic [1:0]       idx;
  logic [PW-1:0]    pix;
  logic [3:0][15:0] slots;
  logic [3:0][15:0] fill;
  logic [15:0]      cvt;
  logic             frame_end;

  // rst_n is active-high despite its name; no pops while it is held
  assign fifo_rd_en = ~rst_n & ~i_empty & ~i_almost_full & (state == COLLECT);
  assign frame_end  = (pix == PW'(TOTAL - 1));

`ifdef HEAD_PACKER_SCALE_EN
  logic signed [31:0] ext;
  logic signed [31:0] scaled;
  assign ext    = {{24{i_data[7]}}, i_data};
  assign scaled = ext <<< SHIFT;
  assign cvt    = (scaled > 32'sd32767)  ? 16'h7FFF :
                  (scaled < -32'sd32768) ? 16'h8000 : scaled[15:0];
`else
  assign cvt = {{8{i_data[7]}}, i_data};
`endif

  // Slots above idx are always zero here, so a short final word needs no masking
  always_comb begin
    fill      = slots;
    fill[idx] = cvt;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= COLLECT;
      idx     <= '0;
      pix     <= '0;
      slots   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      state   <= i_almost_full ? STALL : COLLECT;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      if (fifo_rd_en) begin
        pix <= frame_end ? '0 : pix + 1'b1;
        if (idx == 2'd3 || frame_end) begin
          o_data  <= fill;
          o_valid <= 1'b1;
          o_last  <= frame_end;
          idx     <= '0;
          slots   <= '0;
        end else begin
          slots <= fill;
          idx   <= idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_head_packer.sv
// Randomized and directed check of head_packer against a queue-based packing model.
module tb_head_packer;
  localparam int W = 2, H = 3, TOTAL = W * H, SHIFT_P = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data, one_data;
  logic        empty, af, one_empty, one_af;
  logic        rd, one_rd;
  logic [63:0] odata, one_odata;
  logic        ovalid, olast, one_ovalid, one_olast;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  logic [15:0] elems[$];
  int          cnt;
  logic        prev_af;
  logic [63:0] exp_data;

  always #5 clk = ~clk;

  head_packer #(.IN_WIDTH(W), .IN_HEIGHT(H), .SHIFT(SHIFT_P)) u_dut (
    .clk(clk), .rst_n(rst), .i_data(data), .i_empty(empty), .fifo_rd_en(rd),
    .i_almost_full(af), .o_data(odata), .o_valid(ovalid), .o_last(olast));

  head_packer #(.SHIFT(SHIFT_P)) u_one (
    .clk(clk), .rst_n(rst), .i_data(one_data), .i_empty(one_empty), .fifo_rd_en(one_rd),
    .i_almost_full(one_af), .o_data(one_odata), .o_valid(one_ovalid), .o_last(one_olast));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cvt(input logic [7:0] d);
    int v;
    v = int'($signed(d));
`ifdef HEAD_PACKER_SCALE_EN
    v = v * (2 ** SHIFT_P);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`endif
    return v[15:0];
  endfunction

  task automatic model_reset();
    elems.delete();
    cnt = 0;
    prev_af = 1'b0;
    exp_data = '0;
  endtask

  // One cycle: drive at negedge, check the pop, advance the model, check outputs after the edge
  task automatic step(input logic [7:0] d, input logic e, input logic a);
    logic exp_rd, nv, nl;
    logic [63:0] w;
    @(negedge clk);
    data = d; empty = e; af = a;
    #1;
    exp_rd = !e && !a && !prev_af;
    chk("rd_en", 64'(rd), 64'(exp_rd));
    nv = 1'b0; nl = 1'b0;
    if (exp_rd) begin
      elems.push_back(cvt(d));
      cnt++;
      if (elems.size() == 4 || cnt == TOTAL) begin
        w = '0;
        for (int i = 0; i < elems.size(); i++) w[16*i +: 16] = elems[i];
        exp_data = w;
        nv = 1'b1;
        nl = (cnt == TOTAL);
        elems.delete();
        if (cnt == TOTAL) cnt = 0;
      end
    end
    prev_af = a;
    @(posedge clk);
    #1;
    chk("o_valid", 64'(ovalid), 64'(nv));
    chk("o_last", 64'(olast), 64'(nl));
    chk("o_data", odata, exp_data);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; empty = 1'b0; af = 1'b0; one_empty = 1'b0; one_af = 1'b0;
    #1;
    chk("rst_valid", 64'(ovalid), 64'd0);
    chk("rst_last", 64'(olast), 64'd0);
    chk("rst_data", odata, 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_one_rd", 64'(one_rd), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", 64'(ovalid), 64'd0);
    @(negedge clk);
    rst = 1'b0; empty = 1'b1; one_empty = 1'b1;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; data = '0; empty = 1'b1; af = 1'b0;
    one_data = '0; one_empty = 1'b1; one_af = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Single-pixel frame: one pop yields a one-element final word
    @(negedge clk);
    one_data = 8'hFB; one_empty = 1'b0;
    #1 chk("one_rd_pulse", 64'(one_rd), 64'd1);
    @(posedge clk); #1;
    chk("one_valid", 64'(one_ovalid), 64'd1);
    chk("one_last", 64'(one_olast), 64'd1);
    chk("one_data", one_odata, {48'd0, cvt(8'hFB)});
`ifndef HEAD_PACKER_SCALE_EN
    chk("one_data_const", one_odata, 64'h0000_0000_0000_FFFB);
`endif
    @(negedge clk);
    one_empty = 1'b1;
    #1 chk("one_rd_idle", 64'(one_rd), 64'd0);
    @(posedge clk); #1;
    chk("one_valid_drop", 64'(one_ovalid), 64'd0);
    chk("one_last_drop", 64'(one_olast), 64'd0);
    chk("one_data_hold", one_odata, {48'd0, cvt(8'hFB)});

`ifdef HEAD_PACKER_SCALE_EN
    step(8'h7F, 0, 0); step(8'h80, 0, 0); step(8'h01, 0, 0); step(8'h00, 0, 0);
    chk("scale_word", odata, 64'h0000_0400_8000_7FFF);
    step(8'h05, 0, 0); step(8'h06, 0, 0);
`else
    // 2x3 frame of 1..6: one full word then a two-element final word
    for (int i = 1; i <= 4; i++) step(8'(i), 0, 0);
    chk("frame_w0", odata, 64'h0004_0003_0002_0001);
    chk("frame_w0_last", 64'(olast), 64'd0);
    step(8'd5, 0, 0); step(8'd6, 0, 0);
    chk("frame_w1", odata, 64'h0000_0000_0006_0005);
    chk("frame_w1_last", 64'(olast), 64'd1);
`endif

    // Almost-full hold mid-word; partial slots must survive
    step(8'h11, 0, 0); step(8'h22, 0, 0);
    repeat (4) step(8'hEE, 0, 1);
    for (int i = 0; i < 4 && cnt != 0 && elems.size() != 0; i++) step(8'h33 + 8'(17*i), 0, 0);

    // Reset mid-word; the next word holds only post-reset data
    step(8'h55, 0, 0); step(8'h66, 0, 0); step(8'h77, 0, 0);
    do_reset();
    step(8'hA1, 0, 0); step(8'hA2, 0, 0); step(8'hA3, 0, 0); step(8'hA4, 0, 0);
    chk("post_rst_word", odata, {cvt(8'hA4), cvt(8'hA3), cvt(8'hA2), cvt(8'hA1)});

    // Alternating empty, then fully random traffic with occasional resets
    for (int i = 0; i < 16; i++) step(8'($urandom), 1'(i % 2), 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      else step(8'($urandom), $urandom_range(99) < 40, $urandom_range(99) < 20);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
